// File: rtl/multi_tick_gen_if.sv
// Control and status bundle for multi_tick_gen: per-channel enables, sync/load
// strobes, and the tick/square/divisor outputs.
interface multi_tick_gen_if #(
    parameter int N_CH  = 4,
    parameter int DIV_W = 24
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]       enable;
    logic                  sync;
    logic                  load;
    logic [CH_W-1:0]       load_ch;
    logic [DIV_W-1:0]      load_div;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       sq;
    logic [N_CH*DIV_W-1:0] div_out;

    modport master (
        output enable, sync, load, load_ch, load_div,
        input  tick, sq, div_out
    );

    modport slave (
        input  enable, sync, load, load_ch, load_div,
        output tick, sq, div_out
    );
endinterface

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable clock divider: each channel emits a one-cycle
// tick every D enabled cycles and a square wave toggling on every tick.
module multi_tick_gen #(
    parameter int                    N_CH     = 4,
    parameter int                    DIV_W    = 24,
    parameter logic [N_CH*DIV_W-1:0] DIV_INIT = {N_CH{DIV_W'(24'd8388608)}}
) (
    input  logic              clk,
    input  logic              reset,
    multi_tick_gen_if.slave   bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [DIV_W-1:0] div_q [N_CH];
    logic [DIV_W-1:0] div_d [N_CH];
    logic [DIV_W-1:0] cnt_q [N_CH];
    logic [DIV_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  tick_q, tick_d;
    logic [N_CH-1:0]  sq_q, sq_d;
    logic [N_CH-1:0]  ld_sel;

    // Reload value for a divisor: D-1, but a zero divisor parks the counter at 0.
    function automatic logic [DIV_W-1:0] dec_sat(input logic [DIV_W-1:0] v);
        return (v == '0) ? '0 : v - DIV_W'(1);
    endfunction

    function automatic logic [DIV_W-1:0] init_div(input int ch);
        return DIV_INIT[ch*DIV_W +: DIV_W];
    endfunction

    always_comb begin
        ld_sel = '0;
        tick_d = '0;
        sq_d   = sq_q;
        for (int i = 0; i < N_CH; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = cnt_q[i];
            // Out-of-range load_ch never matches any channel index.
            ld_sel[i] = bus.load && (bus.load_ch == CH_W'(i));
            if (bus.sync || ld_sel[i]) begin
                if (ld_sel[i]) begin
                    div_d[i] = bus.load_div;
                    cnt_d[i] = dec_sat(bus.load_div);
                end else begin
                    cnt_d[i] = dec_sat(div_q[i]);
                end
                if (bus.sync) begin
                    sq_d[i] = 1'b0;
                end
            end else if (bus.enable[i] && (div_q[i] != '0)) begin
                if (cnt_q[i] == '0) begin
                    cnt_d[i]  = div_q[i] - DIV_W'(1);
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] - DIV_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                div_q[i] <= init_div(i);
                cnt_q[i] <= dec_sat(init_div(i));
            end
            tick_q <= '0;
            sq_q   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign bus.tick = tick_q;
    assign bus.sq   = sq_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_div_out
        assign bus.div_out[g*DIV_W +: DIV_W] = div_q[g];
    end
endmodule

// File: tb/tb_multi_tick_gen.sv
// Bench for multi_tick_gen: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an up-counting phase model.
module tb_multi_tick_gen;
    localparam int N = 3;
    localparam int W = 8;
    localparam logic [N*W-1:0] INIT = {8'd4, 8'd3, 8'd5};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_tick_gen_if #(.N_CH(N), .DIV_W(W)) bus ();

    multi_tick_gen #(.N_CH(N), .DIV_W(W), .DIV_INIT(INIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per channel, enabled edges counted since the last restart; a tick
    // falls on every D-th one, and sq is the parity of ticks since reset/sync.
    int          mdiv [N];
    int          mn   [N];
    logic [N-1:0] mtick, msq;
    bit          mvalid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mdiv[i] = int'(INIT[i*W +: W]);
                mn[i]   = 0;
            end
            mtick  = '0;
            msq    = '0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            for (int i = 0; i < N; i++) begin
                bit ld;
                ld = bus.load && (int'(bus.load_ch) == i);
                mtick[i] = 1'b0;
                if (bus.sync || ld) begin
                    if (ld) mdiv[i] = int'(bus.load_div);
                    mn[i] = 0;
                    if (bus.sync) msq[i] = 1'b0;
                end else if (bus.enable[i] && mdiv[i] != 0) begin
                    mn[i] = mn[i] + 1;
                    if (mn[i] == mdiv[i]) begin
                        mn[i]    = 0;
                        mtick[i] = 1'b1;
                        msq[i]   = ~msq[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            logic [N*W-1:0] ediv;
            for (int i = 0; i < N; i++) ediv[i*W +: W] = W'(mdiv[i]);
            check("model_tick", 32'(bus.tick), 32'(mtick));
            check("model_sq", 32'(bus.sq), 32'(msq));
            check("model_div", 32'(bus.div_out), 32'(ediv));
        end
    end

    task automatic do_load(input int ch, input int d);
        bus.load     = 1'b1;
        bus.load_ch  = 2'(ch);
        bus.load_div = W'(d);
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    logic [15:0] T0 = 16'h8420;
    logic [15:0] T1 = 16'h9248;
    logic [15:0] S0 = 16'h83E0;

    initial begin
        bit found;
        reset        = 1'b1;
        bus.enable   = '1;
        bus.sync     = 1'b0;
        bus.load     = 1'b0;
        bus.load_ch  = '0;
        bus.load_div = '0;
        repeat (2) @(negedge clk);
        check("rst_tick", 32'(bus.tick), 32'h0);
        check("rst_sq", 32'(bus.sq), 32'h0);
        reset = 1'b0;

        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check("rel_tick0", 32'(bus.tick[0]), 32'(T0[c]));
            check("rel_tick1", 32'(bus.tick[1]), 32'(T1[c]));
            check("rel_sq0", 32'(bus.sq[0]), 32'(S0[c]));
        end

        // ch0 counter is at 2 after two more edges
        repeat (2) @(negedge clk);
        do_load(0, 2);
        check("ld_div0", 32'(bus.div_out[7:0]), 32'd2);
        check("ld_tick0_a", 32'(bus.tick[0]), 32'd0);
        check("ld_tick1", 32'(bus.tick[1]), 32'd1);
        @(negedge clk); check("ld_tick0_b", 32'(bus.tick[0]), 32'd0);
        @(negedge clk); check("ld_tick0_c", 32'(bus.tick[0]), 32'd1);
        @(negedge clk); check("ld_tick0_d", 32'(bus.tick[0]), 32'd0);
        @(negedge clk); check("ld_tick0_e", 32'(bus.tick[0]), 32'd1);

        do_load(3, 9);
        check("oor_div", 32'(bus.div_out), 32'h040302);

        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            found = bus.tick[1];
        end
        check("pause_found", 32'(found), 32'd1);
        bus.enable[1] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 5) bus.enable[1] = 1'b1;
            @(negedge clk);
            check("pause_tick1", 32'(bus.tick[1]), 32'(k == 7));
        end

        do_load(2, 1);
        check("d1_first", 32'(bus.tick[2]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("d1_tick", 32'(bus.tick[2]), 32'd1);
        end

        do_load(2, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("d0_tick", 32'(bus.tick[2]), 32'd0);
        end

        do_load(0, 4);
        do_load(1, 6);
        repeat (5) @(negedge clk);
        bus.sync = 1'b1;
        @(negedge clk);
        bus.sync = 1'b0;
        check("sync_sq", 32'(bus.sq), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("sync_tick0", 32'(bus.tick[0]), 32'(k % 4 == 0));
            check("sync_tick1", 32'(bus.tick[1]), 32'(k % 6 == 0));
        end

        repeat (3) @(negedge clk);
        bus.sync = 1'b1;
        do_load(0, 2);
        bus.sync = 1'b0;
        check("sl_sq", 32'(bus.sq), 32'd0);
        check("sl_div0", 32'(bus.div_out[7:0]), 32'd2);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("sl_tick0", 32'(bus.tick[0]), 32'(k % 2 == 0));
            check("sl_tick1", 32'(bus.tick[1]), 32'(k == 6));
        end

        do_load(2, 1);
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(negedge clk);
            found = bus.tick[2] && bus.sq[2];
        end
        check("mid_found", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_tick", 32'(bus.tick), 32'd0);
        check("mid_sq", 32'(bus.sq), 32'd0);
        check("mid_div", 32'(bus.div_out), 32'h040305);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) bus.enable[i] = ($urandom_range(0, 7) != 0);
            bus.sync = ($urandom_range(0, 39) == 0);
            bus.load = ($urandom_range(0, 19) == 0);
            bus.load_ch = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: bus.load_div = 8'd0;
                1: bus.load_div = 8'd1;
                2: bus.load_div = 8'd2;
                3: bus.load_div = 8'($urandom_range(3, 12));
                4: bus.load_div = 8'd255;
                default: bus.load_div = 8'($urandom_range(13, 40));
            endcase
            reset = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        bus.sync = 1'b0;
        bus.load = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
